// File: rtl/switch_cond_pkg.sv
// -----------------------------------------------------------------------------
// switch_cond_pkg
// Shared types and helpers for the switch conditioner:
//   - sw_state_t : per-channel debounce FSM state (2-bit encoding)
//   - cnt_width  : counter width helper, $clog2(n) with a floor of 1 bit
// -----------------------------------------------------------------------------
package switch_cond_pkg;

   // Per-channel debounce state. ST_LO is all-zeros so a cleared
   // state register reads as "settled low".
   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      PEND_HI = 2'd1,
      ST_HI   = 2'd2,
      PEND_LO = 2'd3
   } sw_state_t;

   // Width of a counter that must hold values 0 .. n-1.
   // A 1-bit counter is still instantiated for n <= 2 so that the
   // compare logic never sees a zero-width vector.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage : switch_cond_pkg

// File: rtl/switch_debounce_chan.sv
// -----------------------------------------------------------------------------
// switch_debounce_chan
// One switch channel: 2-flop synchroniser, 4-state debounce FSM with a
// hold counter, registered LEVEL plus single-cycle RISE/FALL pulses.
//
// Optional feature (macro SWITCH_COND_AUTOREPEAT_EN):
//   while the channel is settled high, RISE re-fires every REPEAT_CYCLES
//   cycles. Without the macro no repeat counter exists and every accepted
//   press gives exactly one RISE.
//
// Handshake: none. The channel is a free-running level filter; the pulse
// outputs are registered and valid for exactly one clock, with no
// back-pressure from the consumer.
// -----------------------------------------------------------------------------
module switch_debounce_chan
   import switch_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_CYCLES   = 16
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      sw_i,
   output logic      level_o,
   output logic      rise_o,
   output logic      fall_o,
   output sw_state_t state_o
);

   // Both periods must be at least one cycle.
   if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
      $error("switch_debounce_chan: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
   end

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchroniser stages; only s2 is allowed to feed the FSM.
   logic s1_q;
   logic s2_q;

   // FSM and hold counter.
   sw_state_t        state_q;
   sw_state_t        state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Registered outputs.
   logic level_q;
   logic level_d;
   logic rise_q;
   logic rise_d;
   logic fall_q;
   logic fall_d;

`ifdef SWITCH_COND_AUTOREPEAT_EN
   localparam int unsigned RPT_W = cnt_width(REPEAT_CYCLES);
   localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

   // Repeat counter: only advances while the channel stays in ST_HI.
   logic [RPT_W-1:0] rpt_q;
   logic [RPT_W-1:0] rpt_d;
`endif

   // Two-flop synchroniser for the asynchronous raw switch level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= sw_i;
         s2_q <= s1_q;
      end
   end

   // State, counter and output registers; reset discards any pending count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

`ifdef SWITCH_COND_AUTOREPEAT_EN
   // Repeat counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rpt_q <= '0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
`endif

   // Next-state logic: a new level is accepted only after s2 has held the
   // opposite value for DEBOUNCE_CYCLES+1 consecutive edges (one edge to
   // leave the settled state, DEBOUNCE_CYCLES edges in the pending state).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
`ifdef SWITCH_COND_AUTOREPEAT_EN
      // Anything other than "stay in ST_HI" clears the repeat count,
      // which also covers the clear on entry to ST_HI.
      rpt_d   = '0;
`endif

      unique case (state_q)
         ST_LO: begin
            if (s2_q) begin
               state_d = PEND_HI;
               cnt_d   = '0;
            end
         end

         PEND_HI: begin
            if (!s2_q) begin
               // Bounce: fall back silently.
               state_d = ST_LO;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ST_HI;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_HI: begin
            if (!s2_q) begin
               state_d = PEND_LO;
               cnt_d   = '0;
            end else begin
`ifdef SWITCH_COND_AUTOREPEAT_EN
               if (rpt_q == RPT_MAX) begin
                  rise_d = 1'b1;
                  rpt_d  = '0;
               end else begin
                  rpt_d = rpt_q + 1'b1;
               end
`endif
            end
         end

         PEND_LO: begin
            if (s2_q) begin
               // Bounce: return to settled high.
               state_d = ST_HI;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ST_LO;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign state_o = state_q;

endmodule : switch_debounce_chan

// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
// Input stage between a bank of raw switches and synchronous logic.
// Each of NSWITCH channels is synchronised and debounced independently and
// presents a clean LEVEL plus single-cycle RISE/FALL pulses, which are meant
// to be used as clock enables instead of clocking logic from a switch.
//
// Optional feature (macro SWITCH_COND_AUTOREPEAT_EN): RISE auto-repeats
// every REPEAT_CYCLES cycles while a channel is held high.
//
// DBG_STATE exposes each channel's debounce FSM state for observation.
// -----------------------------------------------------------------------------
module switch_conditioner
   import switch_cond_pkg::*;
#(
   parameter int unsigned NSWITCH         = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_CYCLES   = 16
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [NSWITCH-1:0]      SW_IN,
   output logic [NSWITCH-1:0]      LEVEL,
   output logic [NSWITCH-1:0]      RISE,
   output logic [NSWITCH-1:0]      FALL,
   output sw_state_t [NSWITCH-1:0] DBG_STATE
);

   // One fully private conditioner per switch; nothing is shared.
   for (genvar g = 0; g < NSWITCH; g++) begin : g_chan
      switch_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_chan (
         .clk_i   (CLK),
         .rst_ni  (RST_N),
         .sw_i    (SW_IN[g]),
         .level_o (LEVEL[g]),
         .rise_o  (RISE[g]),
         .fall_o  (FALL[g]),
         .state_o (DBG_STATE[g])
      );
   end

endmodule : switch_conditioner

// File: tb/tb_switch_conditioner.sv
// -----------------------------------------------------------------------------
// tb_switch_conditioner
// Scoreboard bench for switch_conditioner (NSWITCH=2, DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=16). A behavioural model predicts each channel's
// {state, level, rise, fall} per clock from the stimulus and pushes it to
// exp_q; the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_switch_conditioner;
   import switch_cond_pkg::*;

   localparam int NSW = 2;
   localparam int DEB = 4;
   localparam int RPT = 16;
   localparam int CW  = 5;          // per channel: state(2) level rise fall
   localparam int W   = CW * NSW;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [NSW-1:0] sw_in = '0;
   logic [NSW-1:0] level;
   logic [NSW-1:0] rise;
   logic [NSW-1:0] fall;
   sw_state_t [NSW-1:0] dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   switch_conditioner #(
      .NSWITCH         (NSW),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (RPT)
   ) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .SW_IN     (sw_in),
      .LEVEL     (level),
      .RISE      (rise),
      .FALL      (fall),
      .DBG_STATE (dbg_state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Counts consecutive edges on which the synchronised input differs from
   // the accepted level; DEB+1 such edges accept the new level.
   logic [W-1:0] exp_q[$];
   bit m_s1  [NSW];
   bit m_s2  [NSW];
   bit m_lvl [NSW];
   int m_run [NSW];
   int m_age [NSW];   // edges spent settled high since entering it

   always @(posedge clk) begin
      logic [W-1:0] e;
      bit r;
      bit f;
      bit was_hi;
      sw_state_t st;
      e = '0;
      for (int c = 0; c < NSW; c++) begin
         r = 1'b0;
         f = 1'b0;
         if (!rst_n) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
            m_run[c] = 0;   m_age[c] = 0;
         end else begin
            was_hi = m_lvl[c] && (m_run[c] == 0);
            if (m_s2[c] != m_lvl[c]) begin
               m_run[c]++;
               if (m_run[c] == DEB + 1) begin
                  m_lvl[c] = m_s2[c];
                  r = m_s2[c];
                  f = !m_s2[c];
                  m_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
            if (was_hi && m_s2[c]) m_age[c]++;
            else                   m_age[c] = 0;
`ifdef SWITCH_COND_AUTOREPEAT_EN
            if (m_age[c] > 0 && (m_age[c] % RPT) == 0) r = 1'b1;
`endif
            m_s2[c] = m_s1[c];
            m_s1[c] = sw_in[c];
         end
         if (m_run[c] == 0) st = m_lvl[c] ? ST_HI : ST_LO;
         else               st = m_lvl[c] ? PEND_LO : PEND_HI;
         e[c*CW +: CW] = {st, m_lvl[c], r, f};
      end
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   int rise_cnt [NSW];
   int fall_cnt [NSW];
   int last_rise_cyc [NSW];
   int last_fall_cyc [NSW];
   int both_rise_cnt = 0;

   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] o;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (!rst_n) e = '0;   // asynchronous reset clears everything at once
         for (int c = 0; c < NSW; c++) begin
            o[c*CW +: CW] = {dbg_state[c], level[c], rise[c], fall[c]};
            check($sformatf("ch%0d_out", c), 32'(o[c*CW +: CW]), 32'(e[c*CW +: CW]));
            if (rise[c]) begin rise_cnt[c]++; last_rise_cyc[c] = cyc; end
            if (fall[c]) begin fall_cnt[c]++; last_fall_cyc[c] = cyc; end
         end
         if (rise == 2'b11) both_rise_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drive(input int c, input bit v, input int n);
      sw_in[c] = v;
      tick(n);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r0, f0, b0, t;
      int exp_rep;

      // Reset with both switches already high.
      rst_n = 1'b0;
      sw_in = 2'b11;
      tick(5);
      check("rst_outputs", 32'({level, rise, fall}), 32'd0);
      rst_n = 1'b1;
      tick(12);
      check("pwrup_rise0", rise_cnt[0], 1);
      check("pwrup_rise1", rise_cnt[1], 1);
      check("pwrup_both", both_rise_cnt, 1);
      check("pwrup_level", 32'(level), 32'(2'b11));

      // Release both, then a clean press/release on ch0.
      sw_in = 2'b00;
      tick(12);
      check("rel_fall0", fall_cnt[0], 1);
      check("rel_fall1", fall_cnt[1], 1);
      t = cyc;
      drive(0, 1'b1, 20);
      check("rise_latency", last_rise_cyc[0] - t, DEB + 3);
      check("press_level", 32'(level[0]), 32'd1);
      t = cyc;
      drive(0, 1'b0, 12);
      check("fall_latency", last_fall_cyc[0] - t, DEB + 3);

      // Bounce shorter than the debounce window.
      r0 = rise_cnt[0];
      drive(0, 1'b1, 3);
      drive(0, 1'b0, 2);
      drive(0, 1'b1, 3);
      drive(0, 1'b0, 10);
      check("bounce_no_rise", rise_cnt[0] - r0, 0);
      drive(0, 1'b1, 10);
      check("bounce_then_hold", rise_cnt[0] - r0, 1);
      drive(0, 1'b0, 12);

      // Reset in the middle of PEND_HI.
      r0 = rise_cnt[0];
      drive(0, 1'b1, 5);
      check("mid_state", 32'(dbg_state[0]), 32'(PEND_HI));
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_level", 32'(level), 32'd0);
      rst_n = 1'b1;
      t = cyc;
      tick(12);
      check("mid_rst_rise", rise_cnt[0] - r0, 1);
      check("mid_rst_latency", last_rise_cyc[0] - t, DEB + 3);
      drive(0, 1'b0, 12);

      // Simultaneous rise, then ch1 bounces alone.
      b0 = both_rise_cnt;
      sw_in = 2'b11;
      tick(12);
      check("simul_rise", both_rise_cnt - b0, 1);
      f0 = fall_cnt[1];
      drive(1, 1'b0, 2);
      drive(1, 1'b1, 2);
      drive(1, 1'b0, 3);
      drive(1, 1'b1, 8);
      check("indep_level", 32'(level), 32'(2'b11));
      check("indep_no_fall", fall_cnt[1] - f0, 0);
      sw_in = 2'b00;
      tick(12);

      // Long hold on ch0.
      r0 = rise_cnt[0];
      f0 = fall_cnt[0];
`ifdef SWITCH_COND_AUTOREPEAT_EN
      exp_rep = 4;
`else
      exp_rep = 1;
`endif
      drive(0, 1'b1, 60);
      check("hold_rise_count", rise_cnt[0] - r0, exp_rep);
      check("hold_no_fall", fall_cnt[0] - f0, 0);
      drive(0, 1'b0, 12);

      // Random runs on both channels.
      for (int i = 0; i < 120; i++) begin
         sw_in[$urandom_range(0, NSW - 1)] = 1'($urandom_range(0, 1));
         tick($urandom_range(1, 8));
      end
      sw_in = 2'b00;
      tick(12);

      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_switch_conditioner
